// File: rtl/sync_fifo.sv
// Synchronous single-clock FIFO with registered read data, occupancy count
// and one-cycle overflow/underflow pulses.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr,
   input  logic             rd,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   output logic             empty,
   output logic             full,
   output logic [$clog2(DEPTH):0] count,
   output logic             overflow,
   output logic             underflow
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [AW:0]      count_q, count_d;
   logic [WIDTH-1:0] data_out_q, data_out_d;
   logic             empty_q, empty_d;
   logic             full_q, full_d;
   logic             overflow_q, overflow_d;
   logic             underflow_q, underflow_d;
   logic             wr_en_c;
   logic             rd_en_c;

   // A write into a full FIFO is only legal when a read frees a slot on the same edge.
   always_comb begin
      wr_en_c     = wr & (~full_q | rd);
      rd_en_c     = rd & ~empty_q;
      wptr_d      = wptr_q;
      rptr_d      = rptr_q;
      count_d     = count_q;
      data_out_d  = data_out_q;
      overflow_d  = wr & full_q & ~rd;
      underflow_d = rd & empty_q & ~wr;

      if (wr_en_c) begin
         wptr_d = wptr_q + AW'(1);
      end
      if (rd_en_c) begin
         rptr_d     = rptr_q + AW'(1);
         data_out_d = mem_q[rptr_q];
      end

      case ({wr_en_c, rd_en_c})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase

      empty_d = (count_d == '0);
      full_d  = (count_d == (AW+1)'(DEPTH));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         count_q     <= '0;
         data_out_q  <= '0;
         empty_q     <= 1'b1;
         full_q      <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         count_q     <= count_d;
         data_out_q  <= data_out_d;
         empty_q     <= empty_d;
         full_q      <= full_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage is not reset; pointers guarantee stale words are never read.
   always_ff @(posedge clk) begin
      if (wr_en_c) begin
         mem_q[wptr_q] <= data_in;
      end
   end

   assign data_out  = data_out_q;
   assign empty     = empty_q;
   assign full      = full_q;
   assign count     = count_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: the driver queues expected read data, a
// monitor compares it against data_out after each expected read.
module tb_sync_fifo;

   logic       clk;
   logic       rst;
   logic       wr;
   logic       rd;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic       empty;
   logic       full;
   logic [3:0] count;
   logic       overflow;
   logic       underflow;

   logic       exp_rd;
   logic [7:0] exp_q[$];
   logic [7:0] mon_exp;
   int         tests;
   int         fails;

   sync_fifo #(.WIDTH(8), .DEPTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .wr        (wr),
      .rd        (rd),
      .data_in   (data_in),
      .data_out  (data_out),
      .empty     (empty),
      .full      (full),
      .count     (count),
      .overflow  (overflow),
      .underflow (underflow)
   );

   always #5 clk = ~clk;

   // Monitor: every edge flagged as a read must present the next queued word.
   always @(posedge clk) begin
      if (exp_rd) begin
         #1;
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL rd_data: got %0h but nothing was expected", data_out);
         end else begin
            mon_exp = exp_q.pop_front();
            if (data_out !== mon_exp) begin
               fails++;
               $display("FAIL rd_data: got %0h want %0h", data_out, mon_exp);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Drive one cycle from posedge+1, return at the following posedge+1.
   task automatic cyc(input logic w, input logic r, input logic [7:0] d,
                      input logic ev, input logic [7:0] evv);
      wr      = w;
      rd      = r;
      data_in = d;
      exp_rd  = ev;
      if (ev) exp_q.push_back(evv);
      @(posedge clk);
      #1;
      wr     = 1'b0;
      rd     = 1'b0;
      exp_rd = 1'b0;
   endtask

   task automatic chk_flags(input string tag, input logic [3:0] c, input logic e, input logic f);
      chk({tag, "_count"}, 32'(count), 32'(c));
      chk({tag, "_empty"}, 32'(empty), 32'(e));
      chk({tag, "_full"},  32'(full),  32'(f));
   endtask

   logic [7:0] pat [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11, 8'h22, 8'h33, 8'h44};

   initial begin
      clk = 1'b0; rst = 1'b0; wr = 1'b0; rd = 1'b0; data_in = 8'h00; exp_rd = 1'b0;
      tests = 0; fails = 0;

      // Reset held: activity on wr/rd must be ignored.
      #1;
      for (int i = 0; i < 4; i++) begin
         cyc(i[0], ~i[0], 8'h11, 1'b0, 8'h00);
         chk_flags("rst_hold", 4'd0, 1'b1, 1'b0);
         chk("rst_hold_dout", 32'(data_out), 32'h00);
      end
      chk("rst_ovf", 32'(overflow), 0);
      chk("rst_udf", 32'(underflow), 0);
      rst = 1'b1;
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);

      // Fill on alternate cycles.
      for (int i = 0; i < 8; i++) begin
         cyc(1'b1, 1'b0, pat[i], 1'b0, 8'h00);
         if (i == 0) chk_flags("first_wr", 4'd1, 1'b0, 1'b0);
         cyc(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
      end
      chk_flags("filled", 4'd8, 1'b0, 1'b1);
      cyc(1'b1, 1'b0, 8'h55, 1'b0, 8'h00);
      chk("ovf_pulse", 32'(overflow), 1);
      chk_flags("ovf", 4'd8, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
      chk("ovf_clear", 32'(overflow), 0);

      // Two reads from full.
      cyc(1'b0, 1'b1, 8'h00, 1'b1, 8'h11);
      cyc(1'b0, 1'b1, 8'h00, 1'b1, 8'h22);
      chk_flags("two_rd", 4'd6, 1'b0, 1'b0);

      // Drain, then one extra read underflows.
      for (int i = 2; i < 8; i++) cyc(1'b0, 1'b1, 8'h00, 1'b1, pat[i]);
      chk_flags("drained", 4'd0, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 8'h00, 1'b0, 8'h00);
      chk("udf_pulse", 32'(underflow), 1);
      chk("udf_dout_hold", 32'(data_out), 32'h44);
      chk("udf_empty", 32'(empty), 1);
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
      chk("udf_clear", 32'(underflow), 0);

      // Simultaneous rd/wr with count=3 preserves order.
      cyc(1'b1, 1'b0, 8'h01, 1'b0, 8'h00);
      cyc(1'b1, 1'b0, 8'h02, 1'b0, 8'h00);
      cyc(1'b1, 1'b0, 8'h03, 1'b0, 8'h00);
      cyc(1'b1, 1'b1, 8'hA5, 1'b1, 8'h01);
      chk_flags("rw_mid", 4'd3, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 8'h00, 1'b1, 8'h02);
      cyc(1'b0, 1'b1, 8'h00, 1'b1, 8'h03);
      cyc(1'b0, 1'b1, 8'h00, 1'b1, 8'hA5);
      chk_flags("rw_mid_drain", 4'd0, 1'b1, 1'b0);

      // Simultaneous rd/wr when full; write pointer wraps past 7 here.
      for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 8'hB0 + 8'(i), 1'b0, 8'h00);
      chk_flags("full2", 4'd8, 1'b0, 1'b1);
      cyc(1'b1, 1'b1, 8'hC3, 1'b1, 8'hB0);
      chk_flags("rw_full", 4'd8, 1'b0, 1'b1);
      chk("rw_full_ovf", 32'(overflow), 0);
      for (int i = 1; i < 8; i++) cyc(1'b0, 1'b1, 8'h00, 1'b1, 8'hB0 + 8'(i));
      cyc(1'b0, 1'b1, 8'h00, 1'b1, 8'hC3);
      chk_flags("full2_drain", 4'd0, 1'b1, 1'b0);

      // Simultaneous rd/wr when empty: write only, no bypass, no underflow.
      cyc(1'b1, 1'b1, 8'h5A, 1'b0, 8'h00);
      chk_flags("rw_empty", 4'd1, 1'b0, 1'b0);
      chk("rw_empty_dout", 32'(data_out), 32'hC3);
      chk("rw_empty_udf", 32'(underflow), 0);
      cyc(1'b0, 1'b1, 8'h00, 1'b1, 8'h5A);

      // Asynchronous reset mid-operation discards entries.
      cyc(1'b1, 1'b0, 8'hE1, 1'b0, 8'h00);
      cyc(1'b1, 1'b0, 8'hE2, 1'b0, 8'h00);
      cyc(1'b1, 1'b0, 8'hE3, 1'b0, 8'h00);
      chk("pre_rst_count", 32'(count), 3);
      #1 rst = 1'b0;
      #1;
      chk_flags("async_rst", 4'd0, 1'b1, 1'b0);
      chk("async_rst_dout", 32'(data_out), 32'h00);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      cyc(1'b1, 1'b0, 8'h77, 1'b0, 8'h00);
      cyc(1'b0, 1'b1, 8'h00, 1'b1, 8'h77);
      chk_flags("post_rst", 4'd0, 1'b1, 1'b0);

      cyc(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
      chk("scoreboard_left", 32'(exp_q.size()), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, meaning the number of storage entries; legal values are powers of two, at least 2.
REQ-003 SHALL have derived localparam AW = log2(DEPTH), meaning the pointer index width.
REQ-004 SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  meaning the reset, asynchronous and active-low.
REQ-006 SHALL have port wr  input  1  meaning the write request, sampled on the rising edge of clk.
REQ-007 SHALL have port rd  input  1  meaning the read request, sampled on the rising edge of clk.
REQ-008 SHALL have port data_in  input  WIDTH  meaning the write data, captured when a write is accepted.
REQ-009 SHALL have port data_out  output  WIDTH  meaning the registered read data.
REQ-010 SHALL have port empty  output  1  meaning the FIFO holds 0 entries.
REQ-011 SHALL have port full  output  1  meaning the FIFO holds DEPTH entries.
REQ-012 SHALL have port count  output  AW+1  meaning the current occupancy, 0..DEPTH.
REQ-013 SHALL have port overflow  output  1  meaning a one-cycle pulse: write rejected.
REQ-014 SHALL have port underflow  output  1  meaning a one-cycle pulse: read rejected.

Function
REQ-015 SHALL use a storage array of DEPTH x WIDTH, a write pointer, a read pointer (AW bits each, wrap modulo DEPTH) and an occupancy counter.
REQ-016 SHALL accept a write when wr=1 and (full=0 or rd=1 with full=1): mem[wptr] <= data_in, wptr+1 (wraps DEPTH-1 -> 0).
REQ-017 SHALL accept a read when rd=1 and empty=0: data_out <= mem[rptr], rptr+1 (wraps); read latency is 1 clk, with data valid after the edge that samples rd.
REQ-018 SHALL hold data_out at its last value when no read is accepted.
REQ-019 SHALL, on simultaneous rd=1 and wr=1 with 0 < count < DEPTH, perform both; count is unchanged.
REQ-020 SHALL, when full and rd=wr=1, perform both the read and the write; count stays DEPTH.
REQ-021 SHALL, when empty and rd=wr=1, perform the write only (no bypass); data_out is unchanged, count becomes 1, and underflow does not pulse.
REQ-022 SHALL update count +1 on a write-only, -1 on a read-only, and leave it unchanged otherwise.
REQ-023 SHALL drive empty = (count==0) and full = (count==DEPTH), consistent with the count register in the same cycle.
REQ-024 SHALL pulse overflow high for exactly one clk cycle after an edge where wr=1 and full=1 and rd=0; that write is ignored with no pointer or data change.
REQ-025 SHALL pulse underflow high for exactly one clk cycle after an edge where rd=1, empty=1 and wr=0; that read is ignored.
REQ-026 SHALL never return a location not written since reset.

Reset
REQ-027 SHALL, while rst=0, immediately (asynchronously) force wptr=0, rptr=0, count=0, data_out=0, empty=1, full=0, overflow=0 and underflow=0.
REQ-028 SHALL ignore rd and wr while rst=0; reset held indefinitely keeps all outputs at their reset values.
REQ-029 SHALL leave memory contents uncleared by reset; stale contents are unreachable.
REQ-030 SHALL, on reset mid-operation, discard all stored entries; operation resumes on the first rising edge after rst returns to 1.

Verification
REQ-031 SHALL pass this scenario: hold rst=0 for several cycles while toggling wr/rd with data_in=8'h11 -> empty=1, full=0, count=0 and data_out=8'h00 throughout.
REQ-032 SHALL pass this scenario: after reset, write 11,22,33,44,11,22,33,44 on alternate cycles -> count=8, full=1 after the 8th write; a 9th write of 8'h55 -> overflow pulse, count stays 8.
REQ-033 SHALL pass this scenario: from full, two single-cycle reads -> data_out=8'h11 then 8'h22, count=6, full=0.
REQ-034 SHALL pass this scenario: drain all remaining entries and then read once more -> data_out holds the last value (8'h44), underflow pulses, empty=1.
REQ-035 SHALL pass this scenario: with count=3, assert rd=wr=1 for one edge with 8'hA5 -> count stays 3, and 8'hA5 is returned after the other entries (order preserved); repeat when full -> full remains 1.
REQ-036 SHALL pass this scenario: write 3 entries, pulse rst low between edges -> empty=1 and count=0 immediately; then write 8'h77 and read -> 8'h77 is returned.
